// File: rtl/input_cmd_arbiter.sv
// Frame-sampled button/gravity command arbiter feeding the grid controller.
// Optional DAS auto-repeat for Left/Right/Down is built when AUTO_REPEAT_EN is defined.
//
// state | meaning
// IDLE  | no command offered; loads a pending user (priority) or gravity request
// ISSUE | cmd_valid high, cmd held until cmd_ready
module input_cmd_arbiter #(
  parameter int DAS_DELAY = 16,
  parameter int DAS_RATE  = 6,
  parameter int CNT_W     = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic [3:0]       button_code,
  input  logic [CNT_W-1:0] drop_period,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [2:0]       cmd,
  output logic             paused
);

  localparam logic [2:0] CMD_GRAVITY   = 3'd6;
  localparam logic [2:0] CMD_HARD_DROP = 3'd7;
  localparam logic [3:0] CODE_START    = 4'd4;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       prev_code;
  logic             user_pend, grav_pend;
  logic [2:0]       user_cmd;
  logic [CNT_W-1:0] grav_cnt;

  logic [3:0]       code_s;
  logic             new_press, start_press, active_tick;
  logic [2:0]       press_cmd;
  logic             user_req, das_fire;
  logic             accept, hard_accept;
  logic [CNT_W-1:0] period_eff;
  logic [CNT_W:0]   grav_next;
  logic             grav_hit;
  logic             load_user, load_grav;

  function automatic logic [2:0] map_code(input logic [3:0] code);
    case (code)
      4'd1:    map_code = 3'd3;
      4'd2:    map_code = 3'd4;
      4'd5:    map_code = 3'd7;
      4'd6:    map_code = 3'd5;
      4'd7:    map_code = 3'd1;
      4'd8:    map_code = 3'd2;
      default: map_code = 3'd0;
    endcase
  endfunction

  // Codes 9-15 fold to "none" so they also count as a release for press detection.
  assign code_s      = (button_code > 4'd8) ? 4'd0 : button_code;
  assign new_press   = frame_tick && (code_s != 4'd0) && (code_s != prev_code);
  assign start_press = new_press && (code_s == CODE_START);
  assign active_tick = frame_tick && !paused;
  assign press_cmd   = map_code(code_s);
  assign user_req    = active_tick && ((new_press && (press_cmd != 3'd0)) || das_fire);

  assign accept      = cmd_valid && cmd_ready;
  assign hard_accept = accept && (cmd == CMD_HARD_DROP);

  assign period_eff  = (drop_period == '0) ? CNT_W'(1) : drop_period;
  assign grav_next   = {1'b0, grav_cnt} + (CNT_W+1)'(1);
  assign grav_hit    = grav_next >= {1'b0, period_eff};

`ifdef AUTO_REPEAT_EN
  logic [CNT_W-1:0] das_cnt;
  logic             repeatable, held;

  assign repeatable = (code_s == 4'd6) || (code_s == 4'd7) || (code_s == 4'd8);
  assign held       = frame_tick && repeatable && (code_s == prev_code);
  assign das_fire   = held && ((das_cnt + CNT_W'(1)) == CNT_W'(DAS_DELAY));

  // Reloading to DAS_DELAY-DAS_RATE makes the next fire land DAS_RATE ticks later.
  always_ff @(posedge clk) begin
    if (reset) begin
      das_cnt <= '0;
    end else if (active_tick) begin
      if (new_press && repeatable)
        das_cnt <= CNT_W'(1);
      else if (held)
        das_cnt <= das_fire ? CNT_W'(DAS_DELAY - DAS_RATE) : das_cnt + CNT_W'(1);
      else
        das_cnt <= '0;
    end
  end
`else
  assign das_fire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    load_user = 1'b0;
    load_grav = 1'b0;
    case (state_q)
      IDLE: begin
        if (!paused) begin
          if (user_pend) begin
            load_user = 1'b1;
            state_d   = ISSUE;
          end else if (grav_pend) begin
            load_grav = 1'b1;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (cmd_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_valid = (state_q == ISSUE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cmd       <= 3'd0;
      paused    <= 1'b0;
      prev_code <= 4'd0;
      user_pend <= 1'b0;
      user_cmd  <= 3'd0;
      grav_pend <= 1'b0;
      grav_cnt  <= '0;
    end else begin
      state_q <= state_d;

      if (load_user)      cmd <= user_cmd;
      else if (load_grav) cmd <= CMD_GRAVITY;

      if (frame_tick)  prev_code <= code_s;
      if (start_press) paused    <= !paused;

      // A fresh request overrides the clear from loading, so a newer press is never lost.
      if (paused) begin
        user_pend <= 1'b0;
      end else if (user_req) begin
        user_pend <= 1'b1;
        user_cmd  <= press_cmd;
      end else if (load_user) begin
        user_pend <= 1'b0;
      end

      if (hard_accept)      grav_cnt <= '0;
      else if (active_tick) grav_cnt <= grav_hit ? '0 : grav_next[CNT_W-1:0];

      if (paused || hard_accept)     grav_pend <= 1'b0;
      else if (active_tick && grav_hit) grav_pend <= 1'b1;
      else if (load_grav)            grav_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_cmd_arbiter.sv
// Self-checking bench for input_cmd_arbiter: per-cycle model compare plus directed literal checks.
module tb_input_cmd_arbiter;

  localparam int DAS_DELAY = 16;
  localparam int DAS_RATE  = 6;
  localparam int CNT_W     = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             frame_tick = 1'b0;
  logic [3:0]       button_code = 4'd0;
  logic [CNT_W-1:0] drop_period = '0;
  logic             cmd_ready = 1'b1;
  logic             cmd_valid;
  logic [2:0]       cmd;
  logic             paused;

  int checks = 0;
  int errors = 0;

  input_cmd_arbiter #(.DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .button_code(button_code),
    .drop_period(drop_period), .cmd_ready(cmd_ready), .cmd_valid(cmd_valid),
    .cmd(cmd), .paused(paused)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cmd_of(input int code);
    case (code)
      1: return 3;  2: return 4;  5: return 7;
      6: return 5;  7: return 1;  8: return 2;
      default: return 0;
    endcase
  endfunction

  // Behavioural model: pending requests and one offered command, advanced once per clock.
  bit model_live = 0;
  bit m_valid, m_paused, m_upend, m_gpend;
  int m_cmd, m_ucmd, m_prev, m_gcnt, m_held;
  int mc, period;
  bit acc, hard, is_press, act, rep_fire, issue_u, issue_g, g_hit;

  always @(posedge clk) begin
    if (reset) begin
      model_live = 1;
      m_valid = 0; m_paused = 0; m_upend = 0; m_gpend = 0;
      m_cmd = 0; m_ucmd = 0; m_prev = 0; m_gcnt = 0; m_held = 0;
    end else begin
      mc       = (button_code > 8) ? 0 : int'(button_code);
      acc      = m_valid && cmd_ready;
      hard     = acc && (m_cmd == 7);
      is_press = frame_tick && mc != 0 && mc != m_prev;
      act      = frame_tick && !m_paused;
      rep_fire = 0;
      if (act) begin
        if (mc == 6 || mc == 7 || mc == 8) m_held = (mc == m_prev) ? m_held + 1 : 1;
        else m_held = 0;
`ifdef AUTO_REPEAT_EN
        if (mc == m_prev && m_held >= DAS_DELAY && ((m_held - DAS_DELAY) % DAS_RATE) == 0)
          rep_fire = 1;
`endif
      end
      issue_u = !m_valid && !m_paused && m_upend;
      issue_g = !m_valid && !m_paused && !m_upend && m_gpend;
      if (m_valid) m_valid = !acc;
      else if (issue_u) begin m_valid = 1; m_cmd = m_ucmd; end
      else if (issue_g) begin m_valid = 1; m_cmd = 6; end

      if (m_paused) m_upend = 0;
      else if (act && ((is_press && cmd_of(mc) != 0) || rep_fire)) begin
        m_upend = 1; m_ucmd = cmd_of(mc);
      end else if (issue_u) m_upend = 0;

      period = (drop_period == 0) ? 1 : int'(drop_period);
      g_hit = 0;
      if (hard) m_gcnt = 0;
      else if (act) begin
        m_gcnt++;
        if (m_gcnt >= period) begin m_gcnt = 0; g_hit = 1; end
      end
      if (m_paused || hard) m_gpend = 0;
      else if (g_hit) m_gpend = 1;
      else if (issue_g) m_gpend = 0;

      if (frame_tick) m_prev = mc;
      if (is_press && mc == 4) m_paused = !m_paused;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("model_valid", cmd_valid, m_valid);
      chk("model_paused", paused, m_paused);
      if (m_valid) chk("model_cmd", cmd, m_cmd);
    end
  end

  // Transfer log of what the DUT actually handed over.
  int cyc_cnt = 0, tick_cnt = 0;
  int xfer_cmd[$], xfer_cyc[$], xfer_tick[$];
  always @(posedge clk) begin
    cyc_cnt++;
    if (!reset && cmd_valid === 1'b1 && cmd_ready) begin
      xfer_cmd.push_back(int'(cmd));
      xfer_cyc.push_back(cyc_cnt);
      xfer_tick.push_back(tick_cnt);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input int dp);
    reset = 1; frame_tick = 0; button_code = 0; cmd_ready = 1; drop_period = CNT_W'(dp);
    cyc(2);
    reset = 0;
    xfer_cmd.delete(); xfer_cyc.delete(); xfer_tick.delete();
    tick_cnt = 0;
  endtask

  task automatic frame(input int code);
    tick_cnt++;
    button_code = 4'(code); frame_tick = 1;
    cyc(1);
    frame_tick = 0;
    cyc(7);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_ticks[$];

    // Reset state and tick-to-valid latency
    do_reset(63);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_paused", paused, 0);
    tick_cnt++;
    button_code = 7; frame_tick = 1;
    cyc(1); frame_tick = 0;
    chk("lat_t1_valid", cmd_valid, 0);
    cyc(1);
    chk("lat_t2_valid", cmd_valid, 1);
    chk("lat_t2_cmd", cmd, 1);
    cyc(1);
    chk("lat_t3_valid", cmd_valid, 0);
    cyc(5);
    repeat (3) frame(0);
    chk("left_once_count", xfer_cmd.size(), 1);

    // Gravity every 3 ticks, then every tick with period 0
    do_reset(3);
    repeat (7) frame(0);
    chk("grav3_count", xfer_cmd.size(), 2);
    if (xfer_cmd.size() == 2) begin
      chk("grav3_cmd0", xfer_cmd[0], 6);
      chk("grav3_tick0", xfer_tick[0], 3);
      chk("grav3_tick1", xfer_tick[1], 6);
    end
    do_reset(0);
    repeat (4) frame(0);
    chk("grav0_count", xfer_cmd.size(), 4);

    // User and gravity pending together: user first, gravity two cycles later
    do_reset(3);
    frame(0); frame(0); frame(1);
    chk("prio_count", xfer_cmd.size(), 2);
    if (xfer_cmd.size() == 2) begin
      chk("prio_first", xfer_cmd[0], 3);
      chk("prio_second", xfer_cmd[1], 6);
      chk("prio_gap", xfer_cyc[1] - xfer_cyc[0], 2);
    end

    // Back-pressure holds SOFT_DROP; RIGHT pressed meanwhile follows
    do_reset(63);
    cmd_ready = 0;
    frame(6);
    chk("bp_valid_a", cmd_valid, 1);
    chk("bp_cmd_a", cmd, 5);
    frame(8);
    chk("bp_valid_b", cmd_valid, 1);
    chk("bp_cmd_b", cmd, 5);
    chk("bp_none_yet", xfer_cmd.size(), 0);
    cmd_ready = 1;
    cyc(8);
    chk("bp_count", xfer_cmd.size(), 2);
    if (xfer_cmd.size() == 2) begin
      chk("bp_first", xfer_cmd[0], 5);
      chk("bp_second", xfer_cmd[1], 2);
    end

    // Pause freezes gravity, ignores buttons; resume continues the count
    do_reset(3);
    frame(0);
    frame(4);
    chk("pause_on", paused, 1);
    frame(7); frame(8); frame(0); frame(0);
    chk("pause_quiet", xfer_cmd.size(), 0);
    frame(4);
    chk("pause_off", paused, 0);
    chk("pause_still_quiet", xfer_cmd.size(), 0);
    frame(0);
    chk("resume_count", xfer_cmd.size(), 1);
    if (xfer_cmd.size() == 1) chk("resume_cmd", xfer_cmd[0], 6);

    // Accepted HARD_DROP swallows coincident gravity and restarts the count
    do_reset(3);
    frame(0); frame(0); frame(5);
    chk("hd_count", xfer_cmd.size(), 1);
    if (xfer_cmd.size() == 1) chk("hd_cmd", xfer_cmd[0], 7);
    frame(0); frame(0);
    chk("hd_restart_a", xfer_cmd.size(), 1);
    frame(0);
    chk("hd_restart_b", xfer_cmd.size(), 2);

    // Reset while a command is offered drops it
    do_reset(63);
    cmd_ready = 0;
    button_code = 5; frame_tick = 1;
    cyc(1); frame_tick = 0;
    cyc(1);
    chk("rst_mid_pre", cmd_valid, 1);
    reset = 1;
    cyc(1);
    chk("rst_mid_valid", cmd_valid, 0);
    reset = 0;
    cmd_ready = 1;
    cyc(2);

    // Held LEFT for 30 ticks
    do_reset(63);
    repeat (30) frame(7);
    frame(0);
`ifdef AUTO_REPEAT_EN
    exp_ticks = '{1, 16, 22, 28};
`else
    exp_ticks = '{1};
`endif
    chk("das_count", xfer_cmd.size(), exp_ticks.size());
    if (xfer_cmd.size() == exp_ticks.size()) begin
      foreach (exp_ticks[i]) begin
        chk("das_tick", xfer_tick[i], exp_ticks[i]);
        chk("das_cmd", xfer_cmd[i], 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
